ejtag_dma_arbiter: RTL and testbench
====================================

# ejtag_dma_arbiter

Sequences single EJTAG DMA transactions onto the local bus and arbitrates that bus between the core and the EJTAG DMA engine. It sits between ejtag_control, which supplies the start pulse, direction, size and increment, and the local bus controller. It is clocked by CORE_CLOCK only. It produces byte enables, aligned read data, the completion pulse that clears the DMA start handshake, and a sticky error flag.

## Interface
- STARVE_MAX, 16: cycles a pending DMA may wait behind the core before forced preemption.
- TIMEOUT, 255: cycles in XFER without LB_ACK/LB_ERR before abort. Must fit 8 bits.
- CORE_CLOCK  in  1  sole clock; all state on rising edge.
- RESET_D2_R  in  1  asynchronous, active-high reset.
- EJC_DMASTART  in  1  one-cycle start pulse.
- EJC_DMAREAD  in  1  1 = read, 0 = write.
- EJC_DMASIZE  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- EJC_DMAINC  in  1  post-increment address on success.
- EJDA_ADDR_LD  in  1  load address register from EJDA_ADDR_IN. Ignored while busy.
- EJDA_ADDR_IN  in  32  JTAG-supplied address.
- EJDA_WDATA_IN  in  32  JTAG-supplied write data, LSB-aligned. Captured at start.
- CORE_BUSREQ  in  1  core request. Held until its LB_ACK.
- LB_ACK  in  1  bus transfer complete.
- LB_ERR  in  1  bus error; terminates the transfer.
- LB_RDATA  in  32  bus read data, valid with LB_ACK.
- EJDA_CORE_GNT  out  1  core owns the bus.
- EJDA_REQ  out  1  DMA transfer active on the bus.
- EJDA_ADDR  out  32  address register.
- EJDA_BE  out  4  byte enables.
- EJDA_WRITE  out  1  DMA write strobe qualifier.
- EJDA_WDATA  out  32  lane-replicated write data.
- EJDA_RDATA  out  32  LSB-aligned, zero-extended read result.
- EJDA_DONE  out  1  one-cycle completion pulse, success or error.
- EJDA_ERR  out  1  sticky error flag.
- EJDA_BUSY  out  1  state != IDLE.

## Operation
- FSM states: IDLE, ARB, XFER, DONE.
- IDLE -> ARB on EJC_DMASTART. At start, capture READ, SIZE, INC and WDATA_IN, and clear EJDA_ERR.
- IDLE -> DONE on EJC_DMASTART when the start is illegal. No bus cycle is issued, and ERR is set. Illegal starts:
  - SIZE = 11.
  - Halfword with ADDR[0] = 1.
  - Word with ADDR[1:0] != 0.
- ARB -> XFER in a cycle where either:
  - CORE_BUSREQ = 0, or
  - the starve counter has reached STARVE_MAX and LB_ACK = 1 with the core as owner (preemption at a core transfer boundary).
- Starve counter: increments each cycle in ARB, saturates at STARVE_MAX, clears on leaving ARB.
- XFER -> DONE on LB_ACK, LB_ERR, or timeout counter reaching TIMEOUT.
  - LB_ERR or timeout sets ERR.
  - LB_ACK alone succeeds. If LB_ACK and LB_ERR arrive together, the error wins.
- DONE -> IDLE unconditionally.
- EJDA_CORE_GNT = 1 in IDLE, ARB and DONE; 0 in XFER.
- EJDA_REQ = 1 only in XFER.
- Byte enables (little-endian):
  - byte: 4'b0001 << ADDR[1:0].
  - half: 0011 if ADDR[1] = 0, else 1100.
  - word: 1111.
- Write data lanes: byte replicated to all four lanes; halfword replicated to both halves.
- Read result: LB_RDATA >> (8*ADDR[1:0]), masked to the access size, captured on LB_ACK in XFER. It holds until the next successful read.
- Address increment: on successful completion with INC = 1, ADDR += 1, 2 or 4 by size, modulo 2^32 (FFFF_FFFC + 4 -> 0000_0000). No increment on error.
- EJC_DMASTART while BUSY: ignored, sets ERR, no other effect.
- EJDA_ADDR_LD in IDLE coincident with EJC_DMASTART: the load takes effect first, and the start uses the new address.

## Timing
- Reset values: state IDLE; EJDA_CORE_GNT 1; all other outputs and registers 0 (ADDR, RDATA, counters).
- Reset mid-transfer: abandons the transfer immediately. No DONE pulse. REQ drops asynchronously.
- START sampled at cycle t:
  - ARB at t+1.
  - With CORE_BUSREQ = 0 at t+1, REQ = 1 and GNT = 0 at t+2.
- LB_ACK at cycle k: DONE = 1 and RDATA valid at k+1; IDLE at k+2. Minimum start-to-done latency is 4 cycles with a 1-cycle ACK.
- Illegal start at t: DONE and ERR at t+1.
- Timeout: DONE at XFER entry + TIMEOUT + 1.
- EJDA_ADDR updates in the DONE cycle.

## Test plan
- Word read, ADDR 0x100, core idle, ACK after 2 XFER cycles, LB_RDATA 0xDEADBEEF -> BE 1111, DONE at t+5, RDATA 0xDEADBEEF, ADDR stays 0x100.
- Byte write with INC, ADDR 0x203, WDATA_IN 0x5A -> BE 1000, WDATA 0x5A5A5A5A, WRITE 1, ADDR 0x204 after DONE, ERR 0.
- Halfword start at ADDR 0x101; separately, SIZE 11 -> DONE at t+1, ERR 1, REQ never asserted.
- CORE_BUSREQ held high continuously with ACKs every 3 cycles, STARVE_MAX 16 -> DMA wins at the first core ACK after 16 ARB cycles, and GNT drops the next cycle.
- No ACK, TIMEOUT 255 -> DONE at XFER + 256, ERR 1, ADDR unchanged. Next START clears ERR.
- RESET_D2_R pulsed during XFER -> REQ 0, GNT 1, BUSY 0 immediately, no DONE. Word read at ADDR 0xFFFF_FFFC with INC -> ADDR 0.

Source files
------------

// File: rtl/ejtag_dma_arbiter.sv
// EJTAG DMA sequencer: arbitrates the local bus between the core and a single EJTAG
// DMA transaction, and produces lane-aligned byte enables, write data and read data.
module ejtag_dma_arbiter #(
    parameter int unsigned STARVE_MAX = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        CORE_CLOCK,
    input  logic        RESET_D2_R,
    input  logic        EJC_DMASTART,
    input  logic        EJC_DMAREAD,
    input  logic [1:0]  EJC_DMASIZE,
    input  logic        EJC_DMAINC,
    input  logic        EJDA_ADDR_LD,
    input  logic [31:0] EJDA_ADDR_IN,
    input  logic [31:0] EJDA_WDATA_IN,
    input  logic        CORE_BUSREQ,
    input  logic        LB_ACK,
    input  logic        LB_ERR,
    input  logic [31:0] LB_RDATA,
    output logic        EJDA_CORE_GNT,
    output logic        EJDA_REQ,
    output logic [31:0] EJDA_ADDR,
    output logic [3:0]  EJDA_BE,
    output logic        EJDA_WRITE,
    output logic [31:0] EJDA_WDATA,
    output logic [31:0] EJDA_RDATA,
    output logic        EJDA_DONE,
    output logic        EJDA_ERR,
    output logic        EJDA_BUSY
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ARB, XFER, DONE} state_t;

    state_t      state;
    logic        read_q;
    logic [1:0]  size_q;
    logic        inc_q;
    logic [SW-1:0] starve_cnt;
    logic [7:0]  tmo_cnt;

    logic [31:0] eff_addr;
    logic        illegal;
    logic [3:0]  start_be;
    logic [31:0] start_wdata;
    logic [31:0] rd_shift;
    logic [31:0] rd_result;
    logic [31:0] addr_step;
    logic        preempt;
    logic        xfer_end;

    // A coincident address load takes effect before the start is evaluated.
    assign eff_addr = EJDA_ADDR_LD ? EJDA_ADDR_IN : EJDA_ADDR;

    always_comb begin
        illegal     = 1'b0;
        start_be    = 4'b0000;
        start_wdata = EJDA_WDATA_IN;
        case (EJC_DMASIZE)
            2'b00: begin
                start_be    = 4'b0001 << eff_addr[1:0];
                start_wdata = {4{EJDA_WDATA_IN[7:0]}};
            end
            2'b01: begin
                illegal     = eff_addr[0];
                start_be    = eff_addr[1] ? 4'b1100 : 4'b0011;
                start_wdata = {2{EJDA_WDATA_IN[15:0]}};
            end
            2'b10: begin
                illegal     = (eff_addr[1:0] != 2'b00);
                start_be    = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign rd_shift = LB_RDATA >> {EJDA_ADDR[1:0], 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   rd_result = {24'd0, rd_shift[7:0]};
            2'b01:   rd_result = {16'd0, rd_shift[15:0]};
            default: rd_result = rd_shift;
        endcase
    end

    assign addr_step = 32'd1 << size_q;
    // DMA steals the bus only at a core transfer boundary once it has starved long enough.
    assign preempt   = !CORE_BUSREQ || ((starve_cnt == SW'(STARVE_MAX)) && LB_ACK);
    assign xfer_end  = LB_ACK || LB_ERR || (tmo_cnt == 8'(TIMEOUT));

    always_ff @(posedge CORE_CLOCK or posedge RESET_D2_R) begin
        if (RESET_D2_R) begin
            state         <= IDLE;
            read_q        <= 1'b0;
            size_q        <= 2'b00;
            inc_q         <= 1'b0;
            starve_cnt    <= '0;
            tmo_cnt       <= 8'd0;
            EJDA_CORE_GNT <= 1'b1;
            EJDA_REQ      <= 1'b0;
            EJDA_ADDR     <= 32'd0;
            EJDA_BE       <= 4'b0000;
            EJDA_WRITE    <= 1'b0;
            EJDA_WDATA    <= 32'd0;
            EJDA_RDATA    <= 32'd0;
            EJDA_DONE     <= 1'b0;
            EJDA_ERR      <= 1'b0;
            EJDA_BUSY     <= 1'b0;
        end else begin
            EJDA_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (EJDA_ADDR_LD)
                        EJDA_ADDR <= EJDA_ADDR_IN;
                    if (EJC_DMASTART) begin
                        read_q     <= EJC_DMAREAD;
                        size_q     <= EJC_DMASIZE;
                        inc_q      <= EJC_DMAINC;
                        EJDA_BE    <= start_be;
                        EJDA_WDATA <= start_wdata;
                        EJDA_ERR   <= illegal;
                        EJDA_BUSY  <= 1'b1;
                        if (illegal) begin
                            state     <= DONE;
                            EJDA_DONE <= 1'b1;
                        end else begin
                            state <= ARB;
                        end
                    end
                end
                ARB: begin
                    if (EJC_DMASTART)
                        EJDA_ERR <= 1'b1;
                    if (preempt) begin
                        state         <= XFER;
                        starve_cnt    <= '0;
                        EJDA_CORE_GNT <= 1'b0;
                        EJDA_REQ      <= 1'b1;
                        EJDA_WRITE    <= !read_q;
                    end else if (starve_cnt != SW'(STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                XFER: begin
                    if (EJC_DMASTART)
                        EJDA_ERR <= 1'b1;
                    if (xfer_end) begin
                        state         <= DONE;
                        tmo_cnt       <= 8'd0;
                        EJDA_CORE_GNT <= 1'b1;
                        EJDA_REQ      <= 1'b0;
                        EJDA_WRITE    <= 1'b0;
                        EJDA_DONE     <= 1'b1;
                        // Error wins over a simultaneous ACK; a timeout has no ACK.
                        if (LB_ERR || !LB_ACK) begin
                            EJDA_ERR <= 1'b1;
                        end else begin
                            if (read_q)
                                EJDA_RDATA <= rd_result;
                            if (inc_q)
                                EJDA_ADDR <= EJDA_ADDR + addr_step;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (EJC_DMASTART)
                        EJDA_ERR <= 1'b1;
                    state     <= IDLE;
                    EJDA_BUSY <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ejtag_dma_arbiter.sv
// Randomized scoreboard bench for ejtag_dma_arbiter: a driver issues DMA transactions and
// plays bus/core, a reference model predicts results, and a monitor checks them at DONE.
module tb_ejtag_dma_arbiter;
    localparam int STARVE_MAX = 16;
    localparam int TIMEOUT    = 255;

    logic        clk = 1'b0;
    logic        RESET_D2_R;
    logic        EJC_DMASTART, EJC_DMAREAD, EJC_DMAINC, EJDA_ADDR_LD;
    logic [1:0]  EJC_DMASIZE;
    logic [31:0] EJDA_ADDR_IN, EJDA_WDATA_IN, LB_RDATA;
    logic        CORE_BUSREQ, LB_ACK, LB_ERR;
    logic        EJDA_CORE_GNT, EJDA_REQ, EJDA_WRITE, EJDA_DONE, EJDA_ERR, EJDA_BUSY;
    logic [31:0] EJDA_ADDR, EJDA_WDATA, EJDA_RDATA;
    logic [3:0]  EJDA_BE;

    ejtag_dma_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .CORE_CLOCK(clk), .RESET_D2_R(RESET_D2_R),
        .EJC_DMASTART(EJC_DMASTART), .EJC_DMAREAD(EJC_DMAREAD), .EJC_DMASIZE(EJC_DMASIZE),
        .EJC_DMAINC(EJC_DMAINC), .EJDA_ADDR_LD(EJDA_ADDR_LD), .EJDA_ADDR_IN(EJDA_ADDR_IN),
        .EJDA_WDATA_IN(EJDA_WDATA_IN), .CORE_BUSREQ(CORE_BUSREQ), .LB_ACK(LB_ACK),
        .LB_ERR(LB_ERR), .LB_RDATA(LB_RDATA), .EJDA_CORE_GNT(EJDA_CORE_GNT),
        .EJDA_REQ(EJDA_REQ), .EJDA_ADDR(EJDA_ADDR), .EJDA_BE(EJDA_BE),
        .EJDA_WRITE(EJDA_WRITE), .EJDA_WDATA(EJDA_WDATA), .EJDA_RDATA(EJDA_RDATA),
        .EJDA_DONE(EJDA_DONE), .EJDA_ERR(EJDA_ERR), .EJDA_BUSY(EJDA_BUSY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bus;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        write;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int txn_id = 0;
    logic [31:0] m_addr  = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    logic        seen_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (txn %0d): got %h expected %h", name, txn_id, act, exp);
        end
    endtask

    // Monitor: lane checks on the first REQ cycle, result checks on DONE.
    always @(negedge clk) begin
        if (RESET_D2_R) begin
            seen_req = 1'b0;
        end else begin
            if (EJDA_REQ && !seen_req) begin
                seen_req = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_req", 32'(EJDA_REQ), 32'd0);
                end else begin
                    check("req_for_legal", 32'(sb[0].bus), 32'd1);
                    check("be", 32'(EJDA_BE), 32'(sb[0].be));
                    check("wdata", EJDA_WDATA, sb[0].wdata);
                    check("write", 32'(EJDA_WRITE), 32'(sb[0].write));
                end
            end
            if (EJDA_DONE) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(EJDA_DONE), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("err", 32'(EJDA_ERR), 32'(e.err));
                    check("rdata", EJDA_RDATA, e.rdata);
                    check("addr", EJDA_ADDR, e.addr);
                    $display("txn %0d done: addr=%h rdata=%h err=%0b", txn_id, EJDA_ADDR, EJDA_RDATA, EJDA_ERR);
                end
                seen_req = 1'b0;
            end
        end
    end

    // dly < 0 means the bus never answers (timeout).
    task automatic run_txn(input logic rd, input logic [1:0] sz, input logic inc, input logic ld,
                           input logic [31:0] ain, input logic [31:0] wd, input int core_len,
                           input int dly, input logic berr, input logic bstart,
                           input logic [31:0] rdat, input logic rst_mid);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] mask;
        logic        ill, ok;
        int          arb_exp, j, n;
        txn_id++;
        a   = ld ? ain : m_addr;
        ill = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        m_addr = a;
        e.bus   = !ill;
        e.write = !rd;
        case (sz)
            2'd0:    begin e.be = 4'(1 << a[1:0]);      e.wdata = 32'(wd[7:0]) * 32'h0101_0101; mask = 32'hFF;   end
            2'd1:    begin e.be = 4'(3 << (2 * a[1])); e.wdata = 32'(wd[15:0]) * 32'h0001_0001; mask = 32'hFFFF; end
            default: begin e.be = 4'hF;                 e.wdata = wd;                            mask = 32'hFFFF_FFFF; end
        endcase
        ok = !ill && !berr && dly >= 0;
        if (ok) begin
            if (rd)  m_rdata = (rdat >> (8 * a[1:0])) & mask;
            if (inc) m_addr  = a + (32'd1 << sz);
        end
        e.err   = ill || berr || dly < 0 || bstart;
        e.rdata = m_rdata;
        e.addr  = m_addr;
        sb.push_back(e);

        EJC_DMASTART = 1'b1; EJC_DMAREAD = rd; EJC_DMASIZE = sz; EJC_DMAINC = inc;
        EJDA_ADDR_LD = ld; EJDA_ADDR_IN = ain; EJDA_WDATA_IN = wd;
        @(posedge clk); #1;
        EJC_DMASTART = 1'b0; EJDA_ADDR_LD = 1'b0; EJDA_WDATA_IN = $urandom;
        EJC_DMAREAD = $urandom; EJC_DMASIZE = 2'($urandom); EJC_DMAINC = $urandom;
        if (ill) begin
            check("illegal_done_t1", 32'(EJDA_DONE), 32'd1);
            check("illegal_no_req", 32'(EJDA_REQ), 32'd0);
        end else begin
            // First ARB cycle where the core is idle, or a core ACK after STARVE_MAX waits.
            arb_exp = 0;
            for (int k = 0; k < 200; k++) begin
                arb_exp = k + 1;
                if (k >= core_len || (k >= STARVE_MAX && (k % 3) == 2)) break;
            end
            j = 0;
            while (!EJDA_REQ && j < 200) begin
                CORE_BUSREQ  = (j < core_len);
                LB_ACK       = CORE_BUSREQ && (j % 3 == 2);
                LB_RDATA     = $urandom;
                EJC_DMASTART = bstart && (j == 0);
                @(posedge clk); #1;
                j++;
            end
            CORE_BUSREQ = 1'b0; LB_ACK = 1'b0; EJC_DMASTART = 1'b0;
            check("arb_cycles", 32'(j), 32'(arb_exp));
            check("xfer_gnt", 32'(EJDA_CORE_GNT), 32'd0);
            if (rst_mid) begin
                #3 RESET_D2_R = 1'b1;
                #1;
                check("rst_req", 32'(EJDA_REQ), 32'd0);
                check("rst_gnt", 32'(EJDA_CORE_GNT), 32'd1);
                check("rst_busy", 32'(EJDA_BUSY), 32'd0);
                @(posedge clk); #1;
                RESET_D2_R = 1'b0;
                sb.delete();
                m_addr = 32'd0; m_rdata = 32'd0;
                for (int k = 0; k < 3; k++) begin
                    check("rst_no_done", 32'(EJDA_DONE), 32'd0);
                    @(posedge clk); #1;
                end
                check("rst_addr", EJDA_ADDR, 32'd0);
            end else if (dly < 0) begin
                n = 0;
                while (!EJDA_DONE && n < 400) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("timeout_latency", 32'(n), 32'(TIMEOUT + 1));
            end else begin
                if ($urandom % 4 == 0) begin
                    EJDA_ADDR_LD = 1'b1; EJDA_ADDR_IN = $urandom;
                end
                for (int k = 0; k < dly; k++) begin
                    @(posedge clk); #1;
                    EJDA_ADDR_LD = 1'b0;
                end
                LB_ACK = !berr || ($urandom % 2 == 1); LB_ERR = berr; LB_RDATA = rdat;
                @(posedge clk); #1;
                LB_ACK = 1'b0; LB_ERR = 1'b0; EJDA_ADDR_LD = 1'b0; LB_RDATA = $urandom;
                check("done_after_ack", 32'(EJDA_DONE), 32'd1);
            end
        end
        n = 0;
        while (EJDA_BUSY && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("back_to_idle", 32'(EJDA_BUSY), 32'd0);
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          core_len, dly, r;
        RESET_D2_R = 1'b1;
        EJC_DMASTART = 1'b0; EJC_DMAREAD = 1'b0; EJC_DMASIZE = 2'd0; EJC_DMAINC = 1'b0;
        EJDA_ADDR_LD = 1'b0; EJDA_ADDR_IN = 32'd0; EJDA_WDATA_IN = 32'd0;
        CORE_BUSREQ = 1'b0; LB_ACK = 1'b0; LB_ERR = 1'b0; LB_RDATA = 32'd0;
        #12;
        check("reset_gnt", 32'(EJDA_CORE_GNT), 32'd1);
        check("reset_req", 32'(EJDA_REQ), 32'd0);
        check("reset_busy", 32'(EJDA_BUSY), 32'd0);
        check("reset_done", 32'(EJDA_DONE), 32'd0);
        check("reset_err", 32'(EJDA_ERR), 32'd0);
        check("reset_addr", EJDA_ADDR, 32'd0);
        check("reset_rdata", EJDA_RDATA, 32'd0);
        check("reset_be", 32'(EJDA_BE), 32'd0);
        @(posedge clk); #1;
        RESET_D2_R = 1'b0;
        @(posedge clk); #1;

        // Directed: word read, byte write with increment, illegal starts, starvation, timeout.
        run_txn(1'b1, 2'd2, 1'b0, 1'b1, 32'h100, 32'h0, 0, 2, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        run_txn(1'b0, 2'd0, 1'b1, 1'b1, 32'h203, 32'h5A, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        run_txn(1'b1, 2'd1, 1'b0, 1'b1, 32'h101, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        run_txn(1'b1, 2'd3, 1'b0, 1'b1, 32'h100, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        run_txn(1'b1, 2'd1, 1'b0, 1'b1, 32'h202, 32'h0, 1000, 1, 1'b0, 1'b0, 32'h1234_5678, 1'b0);
        run_txn(1'b0, 2'd2, 1'b1, 1'b1, 32'h400, 32'hCAFE_F00D, 0, -1, 1'b0, 1'b0, 32'h0, 1'b0);
        run_txn(1'b1, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 3, 0, 1'b0, 1'b0, 32'h00AB_0000, 1'b0);
        run_txn(1'b1, 2'd2, 1'b0, 1'b1, 32'h800, 32'h0, 0, 1, 1'b1, 1'b0, 32'h0, 1'b0);
        run_txn(1'b1, 2'd2, 1'b0, 1'b1, 32'h800, 32'h0, 0, 3, 1'b0, 1'b1, 32'h0, 1'b1);
        run_txn(1'b1, 2'd2, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            a  = $urandom;
            if ($urandom % 10 < 7) a = a & ~((32'd1 << sz) - 32'd1);
            r  = $urandom % 12;
            core_len = ($urandom % 3 == 0) ? 3 * $urandom_range(1, 8) : 0;
            if ($urandom % 10 == 0) core_len = 1000;
            dly = (r == 0) ? -1 : int'($urandom % 4);
            run_txn(1'($urandom), sz, 1'($urandom), ($urandom % 4 != 0), a, $urandom,
                    core_len, dly, (r == 1), ($urandom % 10 == 0), $urandom, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
